// File: rtl/spi_config_master.sv
// SPI write master for the on-chip register bank.
// Register writes are queued in a small FIFO and sent one at a time as
// 16-bit mode-0 frames {1'b1, addr[6:0], data[7:0]}, MSB first.
// Each SCLK half-period lasts CLK_DIV clk cycles so that a peripheral
// with a 2-flop synchronizer can sample every bit.
module spi_config_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [6:0]               req_addr,
  input  logic [7:0]               req_data,
  output logic                     req_err,
  output logic                     cs,
  output logic                     SCLK,
  output logic                     COPI,
  output logic                     frame_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP
  } state_t;

  state_t          state_q;
  logic [15:0]     mem_q [0:DEPTH-1];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count;
  logic            full, empty, accept, push, pop;
  logic [15:0]     head;
  logic [14:0]     shift_q;
  logic [4:0]      bit_q;
  logic [7:0]      div_q;
  logic            cs_q, sclk_q, copi_q, done_q, err_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == PW'(DEPTH));
  assign empty  = (count == '0);
  assign accept = req_valid && req_ready;
  assign push   = accept && (req_addr <= 7'd4);
  assign pop    = (state_q == S_IDLE) && !empty;
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  assign req_ready  = !full;
  assign fifo_level = count;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign cs         = cs_q;
  assign SCLK       = sclk_q;
  assign COPI       = copi_q;
  assign frame_done = done_q;
  assign req_err    = err_q;

  // Next pointer values; push and pop in one cycle leave the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {1'b1, req_addr, req_data};
  end

  // Pointer registers and the illegal-address error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= accept && (req_addr > 7'd4);
    end
  end

  // Frame sequencer with registered cs/SCLK/COPI/frame_done.
  // Every SCLK high phase is followed by a full low phase, so the last bit
  // also gets CLK_DIV cycles of hold before the trailing cs-low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            shift_q <= head[14:0];
            copi_q  <= head[15];
            cs_q    <= 1'b0;
            bit_q   <= '0;
            div_q   <= '0;
            state_q <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            bit_q   <= bit_q + 1'b1;
            state_q <= S_HIGH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= shift_q[14];
            shift_q <= {shift_q[13:0], 1'b0};
            state_q <= S_LOW;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_LOW: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == 5'd16) begin
              state_q <= S_TRAIL;
            end else begin
              sclk_q  <= 1'b1;
              bit_q   <= bit_q + 1'b1;
              state_q <= S_HIGH;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_TRAIL: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_GAP;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_GAP: begin
          if (div_q == GAP_LAST) begin
            div_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
